// File: rtl/pattern_pkg.sv
// Shared types and constants for the pattern sequencer.
package pattern_pkg;

  localparam int PAT_W = 3;
  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    WAIT_SYNC = 2'd0,
    AUTO      = 2'd1,
    MANUAL    = 2'd2
  } state_e;

  function automatic logic [PAT_W-1:0] next_pat(
    input logic [PAT_W-1:0] p,
    input int               n
  );
    return (int'(p) >= n - 1) ? '0 : p + 1'b1;
  endfunction

endpackage

// File: rtl/pattern_sequencer_btn.sv
// Button conditioner: 2-FF sync, optional stable-time filter, rising-edge pulse.
// The stable-time filter is built only with PATSEQ_DEBOUNCE_EN defined.
module btn_debounce #(
  parameter int DEB_CYCLES = 250000
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic press_o
);

  logic sync1_q, sync2_q;
  logic prev_q, press_q;
  logic level;

  if (DEB_CYCLES < 1) begin : g_bad_deb
    $error("DEB_CYCLES must be at least 1");
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
    end else begin
      sync1_q <= btn_i;
      sync2_q <= sync1_q;
    end
  end

`ifdef PATSEQ_DEBOUNCE_EN
  localparam int DW = $clog2(DEB_CYCLES + 1);

  logic [DW-1:0] cnt_q, cnt_d;
  logic          stable_q, stable_d;

  // Accept a new level only after it differs for DEB_CYCLES cycles in a row.
  always_comb begin
    cnt_d    = '0;
    stable_d = stable_q;
    if (sync2_q != stable_q) begin
      if (cnt_q == DW'(DEB_CYCLES - 1)) begin
        stable_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  assign level = stable_q;
`else
  assign level = sync2_q;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prev_q  <= 1'b0;
      press_q <= 1'b0;
    end else begin
      prev_q  <= level;
      press_q <= level & ~prev_q;
    end
  end

  assign press_o = press_q;

endmodule

// File: rtl/pattern_sequencer.sv
// Test-pattern selector stepping on frame starts, auto or by button.
// Define PATSEQ_DEBOUNCE_EN to add the button stable-time filter.
module pattern_sequencer
  import pattern_pkg::*;
#(
  parameter int NUM_PAT        = 4,
  parameter int FRAMES_PER_PAT = 60,
  parameter int DEB_CYCLES     = 250000
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             VGA_VS,
  input  logic             BTN_NEXT,
  input  logic             AUTO_EN,
  output logic [PAT_W-1:0] PAT_SEL,
  output logic             PAT_UPDATE,
  output logic [CNT_W-1:0] FRAME_CNT
);

  localparam logic [CNT_W-1:0] TC = CNT_W'(FRAMES_PER_PAT - 1);

  if (NUM_PAT < 2 || NUM_PAT > 8) begin : g_bad_np
    $error("NUM_PAT must be 2..8");
  end
  if (FRAMES_PER_PAT < 1 || FRAMES_PER_PAT > 255) begin : g_bad_fpp
    $error("FRAMES_PER_PAT must be 1..255");
  end

  state_e           state_q, state_d;
  logic             vs_q, fs_q;
  logic             pend_q, pend_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             upd_q, upd_d;
  logic             press, tc, adv;

  btn_debounce #(
    .DEB_CYCLES (DEB_CYCLES)
  ) u_btn (
    .clk_i   (CLK),
    .rst_i   (RST),
    .btn_i   (BTN_NEXT),
    .press_o (press)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= WAIT_SYNC;
      vs_q    <= 1'b1;
      fs_q    <= 1'b0;
      pend_q  <= 1'b0;
      pat_q   <= '0;
      cnt_q   <= '0;
      upd_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      vs_q    <= VGA_VS;
      fs_q    <= vs_q & ~VGA_VS;
      pend_q  <= pend_d;
      pat_q   <= pat_d;
      cnt_q   <= cnt_d;
      upd_q   <= upd_d;
    end
  end

  // A press landing on fs is kept for the following frame.
  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    cnt_d   = cnt_q;
    upd_d   = 1'b0;
    pend_d  = pend_q | press;
    tc      = 1'b0;
    adv     = 1'b0;
    if (fs_q) begin
      tc      = (state_q == AUTO) && (cnt_q == TC);
      adv     = pend_q | tc;
      pend_d  = press;
      state_d = AUTO_EN ? AUTO : MANUAL;
      if (adv) begin
        pat_d = next_pat(pat_q, NUM_PAT);
        cnt_d = '0;
        upd_d = 1'b1;
      end else begin
        unique case (state_q)
          AUTO:    cnt_d = cnt_q + 1'b1;
          MANUAL:  cnt_d = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
          default: cnt_d = cnt_q;
        endcase
      end
    end
  end

  assign PAT_SEL    = pat_q;
  assign PAT_UPDATE = upd_q;
  assign FRAME_CNT  = cnt_q;

endmodule

// File: doc/pattern_sequencer.md
PATTERN_SEQUENCER -- requirements
Module: pattern_sequencer

Interface
REQ-001 The block SHALL have parameter NUM_PAT, default 4, meaning the number of selectable test patterns (2..8).
REQ-002 The block SHALL have parameter FRAMES_PER_PAT, default 60, meaning frames shown per pattern in auto mode (1..255).
REQ-003 The block SHALL have parameter DEB_CYCLES, default 250000, meaning the button stable-time in CLK cycles (only used when PATSEQ_DEBOUNCE_EN is defined).
REQ-004 The block SHALL have port CLK  input  1  pixel clock (the same PCK that drives the pattern datapath); the block has one clock.
REQ-005 The block SHALL have port RST  input  1  reset, synchronous to CLK, active-high.
REQ-006 The block SHALL have port VGA_VS  input  1  vertical sync from syncgen, active-low pulse.
REQ-007 The block SHALL have port BTN_NEXT  input  1  asynchronous manual-advance button, active-high.
REQ-008 The block SHALL have port AUTO_EN  input  1  level input: 1 selects auto cycling, 0 selects manual.
REQ-009 The block SHALL have port PAT_SEL  output  3  the current pattern index, registered.
REQ-010 The block SHALL have port PAT_UPDATE  output  1  a one-cycle pulse in the cycle PAT_SEL takes a new value.
REQ-011 The block SHALL have port FRAME_CNT  output  8  frames elapsed on the current pattern, registered.

Function
REQ-012 The frame-start event SHALL be the falling edge of VGA_VS, detected from a registered copy; fs is asserted 1 cycle after the edge is sampled.
REQ-013 The FSM SHALL have the states WAIT_SYNC, AUTO and MANUAL.
REQ-014 FSM transitions SHALL be: WAIT_SYNC->AUTO or MANUAL on the first fs, per AUTO_EN; AUTO->MANUAL on fs with AUTO_EN=0; MANUAL->AUTO on fs with AUTO_EN=1; no other transitions.
REQ-015 The mode change SHALL take effect only at fs, so AUTO_EN toggles mid-frame are ignored until the next frame start.
REQ-016 In AUTO, FRAME_CNT SHALL increment on each fs, and on the fs where FRAME_CNT==FRAMES_PER_PAT-1 it SHALL clear to 0 and PAT_SEL SHALL advance.
REQ-017 A qualified button press (rising edge after conditioning) SHALL set a pending flag; any number of presses within one frame SHALL collapse into one advance.
REQ-018 In AUTO or MANUAL, on fs with pending set, PAT_SEL SHALL advance, FRAME_CNT SHALL clear and pending SHALL clear.
REQ-019 Auto terminal count and pending coinciding on the same fs SHALL produce a single advance.
REQ-020 A press arriving in the same cycle as fs SHALL be held pending for the next fs.
REQ-021 PAT_SEL advance SHALL be modulo NUM_PAT: NUM_PAT-1 wraps to 0.
REQ-022 PAT_SEL and PAT_UPDATE SHALL change only in a cycle following fs, so pattern changes never occur mid-frame.
REQ-023 In MANUAL, FRAME_CNT SHALL keep counting fs and saturate at 255.
REQ-024 A press in WAIT_SYNC SHALL set pending, which is then serviced on the first fs.

Reset
REQ-025 On RST=1, the block SHALL set state=WAIT_SYNC, PAT_SEL=0, PAT_UPDATE=0, FRAME_CNT=0, pending=0, the VS history register=1 and the debounce counter=0.
REQ-026 RST asserted mid-frame or mid-debounce SHALL abort all activity, and the first fs after reset release SHALL NOT advance PAT_SEL unless a new press occurred.

Configuration
REQ-027 With macro PATSEQ_DEBOUNCE_EN defined, BTN_NEXT SHALL be 2-FF synchronized and then qualified only after being stable for DEB_CYCLES consecutive cycles before edge detection.
REQ-028 Without PATSEQ_DEBOUNCE_EN, BTN_NEXT SHALL be 2-FF synchronized and edge-detected directly, and DEB_CYCLES SHALL be unused.

Structure
REQ-029 Shared package pattern_pkg SHALL hold the FSM state enum (WAIT_SYNC, AUTO, MANUAL) and the constant PAT_W=3.
REQ-030 The block SHALL have one sub-module, btn_debounce, containing the synchronizer, the optional stable counter and the rising-edge pulse output.

Verification (bench: NUM_PAT=4, FRAMES_PER_PAT=3, DEB_CYCLES=8, short frames)
REQ-031 Reset then AUTO_EN=1 for 13 frames -> PAT_SEL sequence 0,0,0,1,1,1,2,2,2,3,3,3,0, with PAT_UPDATE pulsed exactly 4 times, each right after fs.
REQ-032 AUTO_EN=0 and 3 clean presses mid-frame within one frame -> exactly one advance 0->1 at the next fs; PAT_SEL stays 1 for the following 5 frames.
REQ-033 Press coinciding with the AUTO terminal-count frame -> single advance (e.g. 1->2, not 1->3), FRAME_CNT=0.
REQ-034 With PATSEQ_DEBOUNCE_EN, a 5-cycle glitch on BTN_NEXT -> no advance; a 12-cycle pulse -> one advance. Without the macro, a 3-cycle pulse -> one advance.
REQ-035 AUTO_EN toggled 1->0 mid-frame at FRAME_CNT=1 -> the state stays AUTO until fs, then MANUAL; PAT_SEL unchanged and FRAME_CNT=2 after that fs.
REQ-036 RST pulsed mid-frame with PAT_SEL=3 and pending set -> all outputs 0 the cycle after reset; no advance at the first subsequent fs.
